// File: rtl/mem_arbiter_pkg.sv
// Shared types and encodings for the two-master memory arbiter.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b11;

   localparam logic OWN_M0 = 1'b0;
   localparam logic OWN_M1 = 1'b1;

   // One memory request as presented by a master and latched onto the memory port.
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  size;
      logic        we;
   } mem_req_t;

   localparam mem_req_t REQ_IDLE = '{addr: 32'd0, data: 32'd0, size: 2'b00, we: 1'b1};

   function automatic mem_req_t pick_req(input logic sel, input mem_req_t r0, input mem_req_t r1);
      mem_req_t r;
      if (sel == OWN_M1) begin
         r = r1;
      end else begin
         r = r0;
      end
      return r;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational winner select between two requesters.
// i_last names the master served most recently (0 = m0, 1 = m1).
module mem_arbiter_rr_pick2
   import mem_arbiter_pkg::*;
(
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_last,
   input  logic i_rr,
   output logic o_grant,
   output logic o_valid
);

   // Tie goes to the master not served last in round-robin mode, else to m0.
   always_comb begin
      o_valid = i_req0 | i_req1;
      if (i_req0 && i_req1) begin
         if (i_rr) begin
            o_grant = ~i_last;
         end else begin
            o_grant = OWN_M0;
         end
      end else if (i_req1) begin
         o_grant = OWN_M1;
      end else begin
         o_grant = OWN_M0;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for a single-port byte-addressable 32-bit memory.
// Each grant runs IDLE -> ACCESS -> DONE: one memory cycle, then a one-cycle ack.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter bit RR = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_m0_req,
   input  logic [31:0] i_m0_addr,
   input  logic [31:0] i_m0_data,
   input  logic [1:0]  i_m0_size,
   input  logic        i_m0_we,
   output logic        o_m0_ack,
   output logic [31:0] o_m0_data,
   input  logic        i_m1_req,
   input  logic [31:0] i_m1_addr,
   input  logic [31:0] i_m1_data,
   input  logic [1:0]  i_m1_size,
   input  logic        i_m1_we,
   output logic        o_m1_ack,
   output logic [31:0] o_m1_data,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_data,
   output logic [1:0]  o_mem_size,
   output logic        o_mem_we,
   input  logic [31:0] i_mem_data,
   output logic        o_busy
);

   state_e      state_q, state_d;
   mem_req_t    req_q, req_d;
   logic        owner_q, owner_d;
   logic        last_q, last_d;
   logic        m0_ack_q, m0_ack_d;
   logic        m1_ack_q, m1_ack_d;
   logic [31:0] m0_data_q, m0_data_d;
   logic [31:0] m1_data_q, m1_data_d;
   logic        busy_q, busy_d;

   mem_req_t    m0_req_s, m1_req_s;
   logic        grant_s, valid_s;

   assign m0_req_s = '{addr: i_m0_addr, data: i_m0_data, size: i_m0_size, we: i_m0_we};
   assign m1_req_s = '{addr: i_m1_addr, data: i_m1_data, size: i_m1_size, we: i_m1_we};

   mem_arbiter_rr_pick2 u_pick (
      .i_req0  (i_m0_req),
      .i_req1  (i_m1_req),
      .i_last  (last_q),
      .i_rr    (RR),
      .o_grant (grant_s),
      .o_valid (valid_s)
   );

   // Next-state and next-output computation for the transaction sequencer.
   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      owner_d   = owner_q;
      last_d    = last_q;
      m0_ack_d  = 1'b0;
      m1_ack_d  = 1'b0;
      m0_data_d = m0_data_q;
      m1_data_d = m1_data_q;
      case (state_q)
         ST_IDLE: begin
            if (valid_s) begin
               state_d = ST_ACCESS;
               req_d   = pick_req(grant_s, m0_req_s, m1_req_s);
               owner_d = grant_s;
               last_d  = grant_s;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            // Write-enable drops with the closing edge so only one write edge is seen.
            state_d  = ST_DONE;
            req_d.we = 1'b1;
            if (owner_q == OWN_M1) begin
               m1_data_d = i_mem_data;
               m1_ack_d  = 1'b1;
            end else begin
               m0_data_d = i_mem_data;
               m0_ack_d  = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d  = ST_IDLE;
            req_d.we = 1'b1;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // Sequencer state and all registered outputs; reset abandons any access in flight.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         req_q     <= REQ_IDLE;
         owner_q   <= OWN_M0;
         last_q    <= OWN_M1;
         m0_ack_q  <= 1'b0;
         m1_ack_q  <= 1'b0;
         m0_data_q <= 32'd0;
         m1_data_q <= 32'd0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         m0_ack_q  <= m0_ack_d;
         m1_ack_q  <= m1_ack_d;
         m0_data_q <= m0_data_d;
         m1_data_q <= m1_data_d;
         busy_q    <= busy_d;
      end
   end

   assign o_mem_addr = req_q.addr;
   assign o_mem_data = req_q.data;
   assign o_mem_size = req_q.size;
   assign o_mem_we   = req_q.we;
   assign o_m0_ack   = m0_ack_q;
   assign o_m1_ack   = m1_ack_q;
   assign o_m0_data  = m0_data_q;
   assign o_m1_data  = m1_data_q;
   assign o_busy     = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte memory model, directed vector table, corner sequences
// and a randomized two-master run against a transaction-level reference model.
module tb_mem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        mem_init;

   logic        m0_req, m0_we, m1_req, m1_we, m0_ack, m1_ack;
   logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd, m0_rd, m1_rd;
   logic [1:0]  m0_size, m1_size;
   logic [31:0] mem_addr, mem_wd, mem_rdata;
   logic [1:0]  mem_size;
   logic        mem_we, busy;

   logic        fp_m0_req, fp_m0_we, fp_m1_req, fp_m1_we, fp_m0_ack, fp_m1_ack;
   logic [31:0] fp_m0_addr, fp_m0_wd, fp_m1_addr, fp_m1_wd, fp_m0_rd, fp_m1_rd;
   logic [1:0]  fp_m0_size, fp_m1_size;
   logic [31:0] fp_mem_addr, fp_mem_wd, fp_mem_rdata;
   logic [1:0]  fp_mem_size;
   logic        fp_mem_we, fp_busy;

   mem_arbiter #(.RR(1'b1)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_m0_req(m0_req), .i_m0_addr(m0_addr), .i_m0_data(m0_wd), .i_m0_size(m0_size),
      .i_m0_we(m0_we), .o_m0_ack(m0_ack), .o_m0_data(m0_rd),
      .i_m1_req(m1_req), .i_m1_addr(m1_addr), .i_m1_data(m1_wd), .i_m1_size(m1_size),
      .i_m1_we(m1_we), .o_m1_ack(m1_ack), .o_m1_data(m1_rd),
      .o_mem_addr(mem_addr), .o_mem_data(mem_wd), .o_mem_size(mem_size), .o_mem_we(mem_we),
      .i_mem_data(mem_rdata), .o_busy(busy)
   );

   mem_arbiter #(.RR(1'b0)) dut_fp (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_m0_req(fp_m0_req), .i_m0_addr(fp_m0_addr), .i_m0_data(fp_m0_wd), .i_m0_size(fp_m0_size),
      .i_m0_we(fp_m0_we), .o_m0_ack(fp_m0_ack), .o_m0_data(fp_m0_rd),
      .i_m1_req(fp_m1_req), .i_m1_addr(fp_m1_addr), .i_m1_data(fp_m1_wd), .i_m1_size(fp_m1_size),
      .i_m1_we(fp_m1_we), .o_m1_ack(fp_m1_ack), .o_m1_data(fp_m1_rd),
      .o_mem_addr(fp_mem_addr), .o_mem_data(fp_mem_wd), .o_mem_size(fp_mem_size), .o_mem_we(fp_mem_we),
      .i_mem_data(fp_mem_rdata), .o_busy(fp_busy)
   );

   // Read-only memory for the fixed-priority instance: data is the inverted address.
   assign fp_mem_rdata = ~fp_mem_addr;

   // Little-endian byte memory, 1 KiB, low address bits index it; accesses align to size.
   function automatic logic [9:0] mbase(input logic [31:0] a, input logic [1:0] s);
      if (s == 2'b11) return {a[9:2], 2'b00};
      else if (s == 2'b00) return a[9:0];
      else return {a[9:1], 1'b0};
   endfunction

   function automatic logic [31:0] shape(input logic [31:0] w, input logic [1:0] s);
      if (s == 2'b00) return w & 32'h0000_00FF;
      else if (s == 2'b11) return w;
      else return w & 32'h0000_FFFF;
   endfunction

   function automatic logic [7:0] init_byte(input int i);
      return 8'((i * 37 + 11) % 256);
   endfunction

   logic [7:0] dev_mem [0:1023];
   logic [7:0] ref_mem [0:1023];
   logic [9:0] dev_base;

   assign dev_base = mbase(mem_addr, mem_size);

   // Device memory: combinational read, write on the rising edge while write-enable is low.
   always_comb begin
      mem_rdata = shape({dev_mem[dev_base + 10'd3], dev_mem[dev_base + 10'd2],
                         dev_mem[dev_base + 10'd1], dev_mem[dev_base]}, mem_size);
   end

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 1024; i++) dev_mem[i] <= init_byte(i);
      end else if (!mem_we) begin
         dev_mem[dev_base] <= mem_wd[7:0];
         if (mem_size != 2'b00) dev_mem[dev_base + 10'd1] <= mem_wd[15:8];
         if (mem_size == 2'b11) begin
            dev_mem[dev_base + 10'd2] <= mem_wd[23:16];
            dev_mem[dev_base + 10'd3] <= mem_wd[31:24];
         end
      end
   end

   function automatic logic [31:0] ref_rd(input logic [31:0] a, input logic [1:0] s);
      logic [9:0] b;
      b = mbase(a, s);
      return shape({ref_mem[b + 10'd3], ref_mem[b + 10'd2], ref_mem[b + 10'd1], ref_mem[b]}, s);
   endfunction

   task automatic ref_wr(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
      logic [9:0] b;
      b = mbase(a, s);
      ref_mem[b] = d[7:0];
      if (s != 2'b00) ref_mem[b + 10'd1] = d[15:8];
      if (s == 2'b11) begin
         ref_mem[b + 10'd2] = d[23:16];
         ref_mem[b + 10'd3] = d[31:24];
      end
   endtask

   int n_checks, n_pass;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
   endtask

   task automatic drive(input bit who, input bit req, input bit we,
                        input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
      if (who) begin
         m1_req = req; m1_we = we; m1_addr = a; m1_size = s; m1_wd = d;
      end else begin
         m0_req = req; m0_we = we; m0_addr = a; m0_size = s; m0_wd = d;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   typedef struct {
      bit          who;
      bit          we;
      logic [31:0] addr;
      logic [1:0]  size;
      logic [31:0] wd;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[12];

   // One isolated transaction from an idle arbiter; checks latency, port values and hold.
   task automatic run_vec(input int idx, input vec_t v);
      string tag;
      tag = $sformatf("vec%0d", idx);
      drive(v.who, 1'b1, v.we, v.addr, v.size, v.wd);
      step();
      chk({tag, "_acc_we"}, 32'(mem_we), 32'(v.we));
      chk({tag, "_acc_addr"}, mem_addr, v.addr);
      chk({tag, "_acc_size"}, 32'(mem_size), 32'(v.size));
      if (!v.we) chk({tag, "_acc_wdata"}, mem_wd, v.wd);
      chk({tag, "_acc_noack"}, 32'(m0_ack | m1_ack), 32'd0);
      step();
      drive(v.who, 1'b0, 1'b1, 32'd0, 2'b00, 32'd0);
      chk({tag, "_done_ack"}, {30'd0, m1_ack, m0_ack}, v.who ? 32'd2 : 32'd1);
      chk({tag, "_done_we"}, 32'(mem_we), 32'd1);
      if (v.we) chk({tag, "_rdata"}, v.who ? m1_rd : m0_rd, v.exp);
      if (!v.we) ref_wr(v.addr, v.size, v.wd);
      step();
      chk({tag, "_idle"}, {30'd0, busy, m0_ack | m1_ack}, 32'd0);
      if (v.we) chk({tag, "_hold"}, v.who ? m1_rd : m0_rd, v.exp);
   endtask

   // Randomized phase: master stimulus and a transaction-level reference model.
   bit          rq[2], rwe[2];
   logic [31:0] ra[2], rdd[2];
   logic [1:0]  rs[2];
   bit          md_act, md_last, md_own, md_we;
   int          md_k;
   logic [31:0] md_a, md_d;
   logic [1:0]  md_s;
   bit          e_ack[2], e_known[2];
   logic [31:0] e_data[2];

   task automatic new_fields(input int m);
      rwe[m] = ($urandom_range(0, 9) < 6);
      ra[m]  = $urandom;
      rs[m]  = 2'($urandom_range(0, 3));
      rdd[m] = $urandom;
   endtask

   task automatic apply_rand();
      drive(1'b0, rq[0], rwe[0], ra[0], rs[0], rdd[0]);
      drive(1'b1, rq[1], rwe[1], ra[1], rs[1], rdd[1]);
   endtask

   // Predict what the arbiter does at the coming rising edge from the present inputs.
   task automatic model_edge();
      logic [31:0] v;
      int          w;
      e_ack[0] = 1'b0;
      e_ack[1] = 1'b0;
      if (!md_act) begin
         if (rq[0] || rq[1]) begin
            if (rq[0] && rq[1]) w = md_last ? 0 : 1;
            else w = rq[1] ? 1 : 0;
            md_own = (w == 1);
            md_last = md_own;
            md_a = ra[w]; md_d = rdd[w]; md_s = rs[w]; md_we = rwe[w];
            md_act = 1'b1;
            md_k = 1;
         end
      end else if (md_k == 1) begin
         v = ref_rd(md_a, md_s);
         w = md_own ? 1 : 0;
         if (md_we) begin
            e_data[w] = v;
            e_known[w] = 1'b1;
         end else begin
            ref_wr(md_a, md_s, md_d);
            e_known[w] = 1'b0;
         end
         e_ack[w] = 1'b1;
         md_k = 2;
      end else begin
         md_act = 1'b0;
         md_k = 0;
      end
   endtask

   logic [31:0] pre_val;

   initial begin
      n_checks = 0;
      n_pass = 0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_byte(i);
      drive(1'b0, 1'b0, 1'b1, 32'd0, 2'b00, 32'd0);
      drive(1'b1, 1'b0, 1'b1, 32'd0, 2'b00, 32'd0);
      fp_m0_req = 1'b0; fp_m0_we = 1'b1; fp_m0_addr = 32'd0; fp_m0_size = 2'b00; fp_m0_wd = 32'd0;
      fp_m1_req = 1'b0; fp_m1_we = 1'b1; fp_m1_addr = 32'd0; fp_m1_size = 2'b00; fp_m1_wd = 32'd0;
      mem_init = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      mem_init = 1'b0;
      rst_n = 1'b1;
      step();

      chk("rst_mem_we", 32'(mem_we), 32'd1);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_data", mem_wd, 32'd0);
      chk("rst_mem_size", 32'(mem_size), 32'd0);
      chk("rst_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
      chk("rst_m0_data", m0_rd, 32'd0);
      chk("rst_m1_data", m1_rd, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);

      // Tie after reset with both held: m0 first, then strict alternation.
      drive(1'b0, 1'b1, 1'b1, 32'h100, 2'b11, 32'd0);
      drive(1'b1, 1'b1, 1'b1, 32'h104, 2'b11, 32'd0);
      for (int c = 1; c <= 13; c++) begin
         step();
         chk($sformatf("tie_ack0_c%0d", c), 32'(m0_ack), 32'(c == 2 || c == 8));
         chk($sformatf("tie_ack1_c%0d", c), 32'(m1_ack), 32'(c == 5 || c == 11));
         chk($sformatf("tie_busy_c%0d", c), 32'(busy), 32'(c <= 11 && (c % 3) != 0));
         if (c == 2) chk("tie_m0_data", m0_rd, ref_rd(32'h100, 2'b11));
         if (c == 5) chk("tie_m1_data", m1_rd, ref_rd(32'h104, 2'b11));
         if (c == 11) begin
            drive(1'b0, 1'b0, 1'b1, 32'd0, 2'b00, 32'd0);
            drive(1'b1, 1'b0, 1'b1, 32'd0, 2'b00, 32'd0);
         end
      end

      // Fixed priority: m1 starves until m0 lets go.
      fp_m0_req = 1'b1; fp_m0_addr = 32'h40; fp_m0_size = 2'b11; fp_m0_wd = 32'hA5A5_0F0F;
      fp_m1_req = 1'b1; fp_m1_addr = 32'h80; fp_m1_size = 2'b11;
      for (int c = 1; c <= 16; c++) begin
         step();
         chk($sformatf("fp_ack0_c%0d", c), 32'(fp_m0_ack), 32'(c == 2 || c == 5 || c == 8 || c == 11));
         chk($sformatf("fp_ack1_c%0d", c), 32'(fp_m1_ack), 32'(c == 14));
         if (c == 1) begin
            chk("fp_acc_addr", fp_mem_addr, 32'h40);
            chk("fp_acc_size", 32'(fp_mem_size), 32'd3);
            chk("fp_acc_wdata", fp_mem_wd, 32'hA5A5_0F0F);
            chk("fp_acc_we", 32'(fp_mem_we), 32'd1);
         end
         if (c == 2) chk("fp_m0_data", fp_m0_rd, ~32'h40);
         if (c == 11) fp_m0_req = 1'b0;
         if (c == 14) begin
            chk("fp_m1_data", fp_m1_rd, ~32'h80);
            fp_m1_req = 1'b0;
         end
         if (c >= 15) chk($sformatf("fp_busy_c%0d", c), 32'(fp_busy), 32'd0);
      end

      vecs[0]  = '{1'b0, 1'b0, 32'h0000_0100, 2'b11, 32'hDEAD_BEEF, 32'h0};
      vecs[1]  = '{1'b0, 1'b1, 32'h0000_0100, 2'b11, 32'h1234_5678, 32'hDEAD_BEEF};
      vecs[2]  = '{1'b1, 1'b0, 32'h0000_0200, 2'b11, 32'h1122_3344, 32'h0};
      vecs[3]  = '{1'b1, 1'b0, 32'h0000_0203, 2'b00, 32'hCCCC_CC5A, 32'h0};
      vecs[4]  = '{1'b0, 1'b1, 32'h0000_0200, 2'b11, 32'h0,         32'h5A22_3344};
      vecs[5]  = '{1'b0, 1'b1, 32'h0000_0202, 2'b01, 32'h0,         32'h0000_5A22};
      vecs[6]  = '{1'b1, 1'b0, 32'h0000_0204, 2'b11, 32'h0000_0000, 32'h0};
      vecs[7]  = '{1'b1, 1'b0, 32'h0000_0206, 2'b01, 32'hFFFF_BEEF, 32'h0};
      vecs[8]  = '{1'b1, 1'b1, 32'h0000_0204, 2'b11, 32'h0,         32'hBEEF_0000};
      vecs[9]  = '{1'b0, 1'b1, 32'h0000_0206, 2'b00, 32'h0,         32'h0000_00EF};
      vecs[10] = '{1'b0, 1'b1, 32'h0000_0101, 2'b10, 32'h0,         32'h0000_BEEF};
      vecs[11] = '{1'b1, 1'b1, 32'h0000_0103, 2'b00, 32'h0,         32'h0000_00DE};
      for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

      // m0 drops req during ACCESS: the latched access still completes once.
      drive(1'b0, 1'b1, 1'b1, 32'h104, 2'b11, 32'd0);
      step();
      drive(1'b0, 1'b0, 1'b1, 32'd0, 2'b00, 32'd0);
      step();
      chk("drop_ack", 32'(m0_ack), 32'd1);
      chk("drop_data", m0_rd, ref_rd(32'h104, 2'b11));
      step();
      chk("drop_idle", {30'd0, busy, m0_ack}, 32'd0);
      step();
      chk("drop_no_second", {30'd0, busy, mem_we}, 32'd1);

      // Reset during ACCESS of an m1 write: write-enable releases at once, nothing lands.
      pre_val = ref_rd(32'h300, 2'b11);
      drive(1'b1, 1'b1, 1'b0, 32'h300, 2'b11, 32'h1122_3344);
      step();
      chk("rsta_we_low", 32'(mem_we), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rsta_we_async", 32'(mem_we), 32'd1);
      chk("rsta_busy", 32'(busy), 32'd0);
      drive(1'b1, 1'b0, 1'b1, 32'd0, 2'b00, 32'd0);
      step();
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         chk($sformatf("rsta_noack_c%0d", c), {30'd0, m1_ack, m0_ack}, 32'd0);
      end
      run_vec(12, '{1'b0, 1'b1, 32'h0000_0300, 2'b11, 32'h0, pre_val});

      // Randomized two-master traffic against the reference model.
      do_reset();
      for (int m = 0; m < 2; m++) begin
         rq[m] = 1'b0; rwe[m] = 1'b1; ra[m] = 32'd0; rs[m] = 2'b00; rdd[m] = 32'd0;
         e_known[m] = 1'b1; e_data[m] = 32'd0; e_ack[m] = 1'b0;
      end
      md_act = 1'b0; md_k = 0; md_last = 1'b1; md_own = 1'b0;
      md_a = 32'd0; md_d = 32'd0; md_s = 2'b00; md_we = 1'b1;
      apply_rand();
      for (int c = 0; c < 450; c++) begin
         model_edge();
         step();
         chk("rnd_ack0", 32'(m0_ack), 32'(e_ack[0]));
         chk("rnd_ack1", 32'(m1_ack), 32'(e_ack[1]));
         chk("rnd_busy", 32'(busy), 32'(md_act));
         chk("rnd_we", 32'(mem_we), (md_act && md_k == 1) ? 32'(md_we) : 32'd1);
         if (md_act && md_k == 1) begin
            chk("rnd_addr", mem_addr, md_a);
            chk("rnd_size", 32'(mem_size), 32'(md_s));
            chk("rnd_wdata", mem_wd, md_d);
         end
         if (e_known[0]) chk("rnd_m0_data", m0_rd, e_data[0]);
         if (e_known[1]) chk("rnd_m1_data", m1_rd, e_data[1]);
         for (int m = 0; m < 2; m++) begin
            if (rq[m]) begin
               if (e_ack[m]) begin
                  if ($urandom_range(0, 1) == 0) rq[m] = 1'b0;
                  else new_fields(m);
               end
            end else if ($urandom_range(0, 9) < 4) begin
               new_fields(m);
               rq[m] = 1'b1;
            end
         end
         apply_rand();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
